// File: rtl/watch_display.sv
// watch_display: multiplexed 6-digit HH.MM.SS driver for a 7-segment display.
// Binary time is snapshotted at each frame boundary and converted to BCD by
// repeated subtraction. The result is held in pending registers and moves to
// the display registers at the next frame boundary, so each scanned frame
// always shows one coherent time.
module watch_display #(
    parameter int unsigned SCAN_DIV   = 4,
    parameter bit          ACTIVE_LOW = 1'b0,
    parameter bit          DP_EN      = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    input  logic [4:0] hours,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       err,
    output logic       busy
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_ZERO = 7'h3F;

    typedef enum logic [2:0] {
        IDLE,
        CONV_S,
        CONV_M,
        CONV_H,
        UPDATE
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div;
    logic [2:0]       idx;

    // Digit registers, index 0 = seconds ones ... index 5 = hours tens.
    logic [5:0][3:0]  disp;
    logic [5:0][3:0]  pend;
    logic             pend_err;

    // Conversion working registers, loaded from the snapshot at the frame boundary.
    logic [5:0]       s_w;
    logic [5:0]       m_w;
    logic [4:0]       h_w;
    logic [2:0]       s_t;
    logic [2:0]       m_t;
    logic [1:0]       h_t;
    logic [3:0]       s_o;
    logic [3:0]       m_o;
    logic [3:0]       h_o;
    logic             rng;

    logic             fb;
    logic [2:0]       idx_c;
    logic             err_c;
    logic [3:0]       digit_c;
    logic [6:0]       seg_c;
    logic             dp_c;
    logic [5:0]       an_c;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign fb = (idx == 3'd5) && (div == DIV_LAST);

    // Next-cycle digit view: outputs are registered, so they are built from the
    // values idx and the display registers will hold after this edge.
    always_comb begin
        idx_c = idx;
        if (div == DIV_LAST) begin
            idx_c = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end
        err_c   = fb ? pend_err : err;
        digit_c = fb ? pend[idx_c] : disp[idx_c];
        seg_c   = err_c ? SEG_DASH : seg_code(digit_c);
        dp_c    = !err_c && DP_EN && ((idx_c == 3'd2) || (idx_c == 3'd4));
        an_c    = 6'b000001 << idx_c;
    end

    // Scan counter, display registers and pin outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div  <= '0;
            idx  <= '0;
            disp <= '0;
            err  <= 1'b0;
            seg  <= SEG_ZERO ^ {7{ACTIVE_LOW}};
            dp   <= ACTIVE_LOW;
            an   <= 6'b000001 ^ {6{ACTIVE_LOW}};
        end else begin
            div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
            idx <= idx_c;
            if (fb) begin
                disp <= pend;
                err  <= pend_err;
            end
            seg <= seg_c ^ {7{ACTIVE_LOW}};
            dp  <= dp_c ^ ACTIVE_LOW;
            an  <= an_c ^ {6{ACTIVE_LOW}};
        end
    end

    // Snapshot and iterative binary-to-BCD conversion, one subtraction per cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            pend     <= '0;
            pend_err <= 1'b0;
            s_w      <= '0;
            m_w      <= '0;
            h_w      <= '0;
            s_t      <= '0;
            m_t      <= '0;
            h_t      <= '0;
            s_o      <= '0;
            m_o      <= '0;
            h_o      <= '0;
            rng      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fb) begin
                        s_w   <= seconds;
                        m_w   <= minutes;
                        h_w   <= hours;
                        s_t   <= '0;
                        m_t   <= '0;
                        h_t   <= '0;
                        rng   <= (seconds > 6'd59) || (minutes > 6'd59) || (hours > 5'd23);
                        busy  <= 1'b1;
                        state <= CONV_S;
                    end
                end
                CONV_S: begin
                    if (s_w >= 6'd10) begin
                        s_w <= s_w - 6'd10;
                        s_t <= s_t + 3'd1;
                    end else begin
                        s_o   <= s_w[3:0];
                        state <= CONV_M;
                    end
                end
                CONV_M: begin
                    if (m_w >= 6'd10) begin
                        m_w <= m_w - 6'd10;
                        m_t <= m_t + 3'd1;
                    end else begin
                        m_o   <= m_w[3:0];
                        state <= CONV_H;
                    end
                end
                CONV_H: begin
                    if (h_w >= 5'd10) begin
                        h_w <= h_w - 5'd10;
                        h_t <= h_t + 2'd1;
                    end else begin
                        h_o   <= h_w[3:0];
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    pend     <= {4'(h_t), h_o, 4'(m_t), m_o, 4'(s_t), s_o};
                    pend_err <= rng;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_watch_display.sv
// tb_watch_display: directed stimulus with a cycle-accurate arithmetic model of
// what the display must show, plus hand-computed frame literals.
module tb_watch_display;

    localparam int SCAN_DIV = 4;
    localparam int FRAME    = 6 * SCAN_DIV;

    logic       clk;
    logic       reset;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;

    logic [6:0] seg,   seg_n;
    logic       dp,    dp_n;
    logic [5:0] an,    an_n;
    logic       err,   err_n;
    logic       busy,  busy_n;

    int errors = 0;
    int checks = 0;

    watch_display #(.SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(1'b0), .DP_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .seconds(seconds), .minutes(minutes), .hours(hours),
        .seg(seg), .dp(dp), .an(an), .err(err), .busy(busy)
    );

    watch_display #(.SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(1'b1), .DP_EN(1'b1)) dut_n (
        .clk(clk), .reset(reset), .seconds(seconds), .minutes(minutes), .hours(hours),
        .seg(seg_n), .dp(dp_n), .an(an_n), .err(err_n), .busy(busy_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Model state: edges since reset, time being shown, last snapshot.
    bit started = 1'b0;
    int n       = 0;
    int sh_s = 0, sh_m = 0, sh_h = 0;
    int pd_s = 0, pd_m = 0, pd_h = 0;
    int last_fb = -1;
    int dur     = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (n=%0d)", nm, act, exp, n);
        end
    endtask

    // Model: a frame boundary happens every FRAME edges after reset release.
    always @(posedge clk) begin
        if (!reset) begin
            started = 1'b1;
            n = 0;
            sh_s = 0; sh_m = 0; sh_h = 0;
            pd_s = 0; pd_m = 0; pd_h = 0;
            last_fb = -1;
        end else begin
            n++;
            if (n % FRAME == 0) begin
                sh_s = pd_s; sh_m = pd_m; sh_h = pd_h;
                pd_s = int'(seconds); pd_m = int'(minutes); pd_h = int'(hours);
                last_fb = n;
                dur = (pd_s / 10 + 1) + (pd_m / 10 + 1) + (pd_h / 10 + 1) + 1;
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        int         i;
        int         d;
        logic       ee;
        logic       eb;
        logic       ed;
        logic [6:0] es;
        logic [5:0] ea;
        logic [6:0] es_n;
        logic [5:0] ea_n;
        if (started) begin
            i  = (n / SCAN_DIV) % 6;
            case (i)
                0:       d = sh_s % 10;
                1:       d = sh_s / 10;
                2:       d = sh_m % 10;
                3:       d = sh_m / 10;
                4:       d = sh_h % 10;
                default: d = sh_h / 10;
            endcase
            ee   = (sh_s > 59) || (sh_m > 59) || (sh_h > 23);
            es   = ee ? 7'h40 : seg_tab[d];
            ed   = !ee && ((i == 2) || (i == 4));
            ea   = 6'(1 << i);
            eb   = (last_fb >= 0) && ((n - last_fb) < dur);
            es_n = ~es;
            ea_n = ~ea;
            chk("model_seg",    32'(seg),    32'(es));
            chk("model_an",     32'(an),     32'(ea));
            chk("model_dp",     32'(dp),     32'(ed));
            chk("model_err",    32'(err),    32'(ee));
            chk("model_busy",   32'(busy),   32'(eb));
            chk("model_seg_al", 32'(seg_n),  32'(es_n));
            chk("model_an_al",  32'(an_n),   32'(ea_n));
            chk("model_dp_al",  32'(dp_n),   32'(!ed));
            chk("model_err_al", 32'(err_n),  32'(ee));
            chk("model_busy_al",32'(busy_n), 32'(eb));
        end
    end

    // Advance to the first negedge after the next frame-boundary edge.
    task automatic next_fb();
        int k;
        k = 0;
        @(negedge clk);
        while ((n % FRAME) != 0 && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
        if ((n % FRAME) != 0) begin
            checks++;
            errors++;
            $display("FAIL fb_align: frame boundary not reached within %0d cycles", 2 * FRAME);
        end
    endtask

    // Check one whole frame against literal codes; starts at a frame start.
    task automatic check_lit(input string nm, input logic [5:0][6:0] lit,
                             input logic [5:0] dpm, input logic e);
        logic [5:0] a;
        logic [6:0] li;
        logic [6:0] li_n;
        logic [5:0] a_n;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) repeat (SCAN_DIV) @(negedge clk);
            a    = 6'(1 << i);
            li   = lit[i];
            li_n = ~li;
            a_n  = ~a;
            chk({nm, "_seg"},    32'(seg),   32'(li));
            chk({nm, "_an"},     32'(an),    32'(a));
            chk({nm, "_dp"},     32'(dp),    32'(dpm[i]));
            chk({nm, "_err"},    32'(err),   32'(e));
            chk({nm, "_seg_al"}, 32'(seg_n), 32'(li_n));
            chk({nm, "_an_al"},  32'(an_n),  32'(a_n));
            chk({nm, "_dp_al"},  32'(dp_n),  32'(!dpm[i]));
        end
    endtask

    initial begin
        int bcnt;
        logic [5:0][6:0] lit;
        reset   = 1'b0;
        seconds = '0;
        minutes = '0;
        hours   = '0;

        // T1 reset
        repeat (3) @(negedge clk);
        chk("rst_an",   32'(an),   32'h01);
        chk("rst_seg",  32'(seg),  32'h3F);
        chk("rst_err",  32'(err),  32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_an_al",  32'(an_n),  32'h3E);
        chk("rst_seg_al", 32'(seg_n), 32'h40);
        reset = 1'b1;
        next_fb();
        next_fb();
        lit = {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        check_lit("t1", lit, 6'b010100, 1'b0);

        // T2 basic 12:34:56
        hours = 5'd12; minutes = 6'd34; seconds = 6'd56;
        next_fb();
        next_fb();
        lit = {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D};
        check_lit("t2", lit, 6'b010100, 1'b0);

        // T3 worst case 23:59:59, busy length
        hours = 5'd23; minutes = 6'd59; seconds = 6'd59;
        next_fb();
        bcnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (busy) bcnt++;
            @(negedge clk);
        end
        chk("t3_busy_cycles", 32'(bcnt), 32'd16);
        next_fb();
        lit = {7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h6D, 7'h6F};
        check_lit("t3", lit, 6'b010100, 1'b0);

        // T4 range error, then recovery
        hours = 5'd0; minutes = 6'd0; seconds = 6'd60;
        next_fb();
        next_fb();
        lit = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        check_lit("t4_err", lit, 6'b000000, 1'b1);
        seconds = 6'd5;
        next_fb();
        next_fb();
        lit = {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h6D};
        check_lit("t4_ok", lit, 6'b010100, 1'b0);

        // T5 coherence: change inputs in the middle of a shown frame
        hours = 5'd1; minutes = 6'd2; seconds = 6'd3;
        next_fb();
        next_fb();
        lit = {7'h3F, 7'h06, 7'h3F, 7'h5B, 7'h3F, 7'h4F};
        for (int i = 0; i < 6; i++) begin
            if (i > 0) repeat (SCAN_DIV) @(negedge clk);
            if (i == 3) begin
                hours = 5'd4; minutes = 6'd5; seconds = 6'd6;
            end
            chk("t5_mid_seg", 32'(seg), 32'(lit[i]));
        end
        next_fb();
        check_lit("t5_old", lit, 6'b010100, 1'b0);
        next_fb();
        lit = {7'h3F, 7'h66, 7'h3F, 7'h6D, 7'h3F, 7'h7D};
        check_lit("t5_new", lit, 6'b010100, 1'b0);

        // T6 reset during minutes conversion
        hours = 5'd23; minutes = 6'd59; seconds = 6'd59;
        next_fb();
        repeat (7) @(negedge clk);
        chk("t6_busy_pre", 32'(busy), 32'h1);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_busy",   32'(busy),  32'h0);
        chk("t6_seg",    32'(seg),   32'h3F);
        chk("t6_an",     32'(an),    32'h01);
        chk("t6_err",    32'(err),   32'h0);
        chk("t6_seg_al", 32'(seg_n), 32'h40);
        reset = 1'b1;
        next_fb();
        lit = {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        check_lit("t6_zero", lit, 6'b010100, 1'b0);
        next_fb();
        lit = {7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h6D, 7'h6F};
        check_lit("t6_after", lit, 6'b010100, 1'b0);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
